fp_uu_rd_tracker: RTL and testbench
===================================

// Module: fp_uu_rd_tracker
// PURPOSE
//  Tracks destination FP registers of instructions in flight inside the pipelined FP unit (FMA/div path).
//  Sits between the ID/EXE issue point and FP_busy_registers and feeds that block.
//  Supplies all_uu_FP_rd[] and clear_last, and receives all_uu_FP_rd_busy[] back.
//  Retires the last stage toward the FP write-back mux and blocks WAW issue onto an in-flight rd.
// PARAMETERS
//  NUM_STAGES  3   pipeline depth of the FP unit; equals num_rds of FP_busy_registers
//  REG_AW      5   FP register address width
// PORTS
//  clk                  in   1           single clock, rising edge
//  reset                in   1           synchronous, active-high
//  issue_valid          in   1           FP instruction in ID/EXE targets the pipelined unit
//  issue_rd             in   REG_AW      its FP rd
//  issue_single_cycle   in   1           single-cycle unit instruction; never tracked
//  branch_hazard        in   1           ID/EXE instruction is being squashed
//  wb_stall             in   1           write-back port busy; whole unit holds
//  issue_ready          out  1           tracker can accept an issue this cycle
//  all_uu_FP_rd         out  REG_AW x N  rd stored in each stage, [0]=youngest, [N-1]=last
//  all_uu_FP_rd_busy    in   N           busy flag of each all_uu_FP_rd[i] from FP_busy_registers
//  uu_valid             out  N           stage occupied
//  uu_live              out  N           uu_valid[i] & all_uu_FP_rd_busy[i]
//  clear_last           out  1           last stage retires this cycle and owns its busy flag
//  retire_valid         out  1           last stage retires this cycle
//  retire_rd            out  REG_AW      all_uu_FP_rd[N-1]
//  uu_count             out  clog2(N+1)  number of occupied stages
//  uu_empty             out  1           uu_count == 0
// BEHAVIOUR
//  - Reset values: all valid bits 0, stored rd 0, uu_count 0, uu_empty 1.
//    All combinational outputs follow from that state (clear_last 0, retire_valid 0, issue_ready 1 when wb_stall=0).
//  - accept = issue_valid & issue_ready & ~issue_single_cycle & ~branch_hazard.
//  - waw_hit = OR over i of (uu_valid[i] & all_uu_FP_rd[i] == issue_rd).
//  - issue_ready = ~wb_stall & ~waw_hit. It is combinational, and it is 0 during reset only through wb_stall.
//  - Advance, when wb_stall=0:
//    - stage[i+1] <= stage[i] for every stage;
//    - stage[0].valid <= accept, and stage[0].rd <= issue_rd when accept;
//    - the old stage[N-1] leaves the unit.
//  - Hold, when wb_stall=1: every stage keeps its state and accept is 0.
//    branch_hazard never affects stages that are already occupied.
//  - Retire outputs:
//    - retire_valid = uu_valid[N-1] & ~wb_stall.
//    - clear_last = retire_valid & all_uu_FP_rd_busy[N-1].
//    - Both are combinational from state. Latency from issue to retire is exactly N cycles when no stall occurs.
//  - Bubbles: invalid stages advance as bubbles, and all_uu_FP_rd of an invalid stage keeps its stale value.
//    Consumers must qualify with uu_valid or uu_live.
//  - rd 0 is a real FP register (f0). It is tracked like any other rd, with no special case.
//  - Retire and accept together: the retire in the same cycle as a new accept is legal.
//    uu_count stays unchanged. waw_hit does include stage N-1, even while it retires, so the same rd cannot re-issue in the retiring cycle.
//  - uu_count is a registered counter:
//    - +1 on accept without retire;
//    - -1 on retire without accept;
//    - otherwise unchanged.
//    It must always equal popcount(uu_valid); a bench asserts this.
//  - Reset asserted mid-operation empties every stage on the next edge. No retire pulses are generated for the dropped entries.
// STRUCTURE
//  - Package fp_uu_pkg holds:
//    - typedef struct packed { logic valid; logic [REG_AW-1:0] rd; } uu_entry_t;
//    - localparam NUM_UU_STAGES = 3 and FP_REG_AW = 5.
//  - Sub-module fp_uu_stage holds one uu_entry_t register with load/hold/clear controls, instantiated N times in a generate loop.
//  - The WAW comparator, counter and retire logic stay in the top module.
// TESTING
//  1. Reset, then issue rd=5 at cycle 0, wb_stall=0: uu_valid=001,010,100 over cycles 1..3.
//     retire_valid=1 and retire_rd=5 at cycle 3; clear_last=1 iff busy[2]=1; uu_empty back to 1 at cycle 4.
//  2. Issue rd=7 at c0, then raise wb_stall for 2 cycles at c2: stage contents frozen during those 2 cycles; retire_valid=0 while stalled.
//     Retire occurs at c5 and uu_count holds at 1 throughout.
//  3. rd=9 in flight, issue rd=9 again: issue_ready=0 until the cycle after rd=9 retires.
//     An issue of rd=10 in the same cycle is accepted.
//  4. Back-to-back issue rd=1,2,3, then rd=4 in the cycle that rd=1 retires: uu_count stays at 3; retire order is 1,2,3,4.
//  5. Issue rd=0 with issue_single_cycle=1, then with branch_hazard=1: neither is tracked and uu_empty stays 1.
//     Issue rd=0 alone is tracked and retire_rd=0.
//  6. Fill 3 stages, assert reset for 1 cycle: all uu_valid=0, uu_count=0, no retire_valid pulse, issue_ready=1 next cycle.

Source files
------------

// File: rtl/fp_uu_rd_tracker_pkg.sv
// Shared types and sizes for the FP pipelined-unit rd tracker.
// The stage entry pairs an occupancy bit with the destination register it tracks.
package fp_uu_pkg;

    localparam int NUM_UU_STAGES = 3;
    localparam int FP_REG_AW     = 5;
    localparam int UU_CNT_W      = $clog2(NUM_UU_STAGES + 1);

    typedef struct packed {
        logic                 valid;
        logic [FP_REG_AW-1:0] rd;
    } uu_entry_t;

endpackage

// File: rtl/fp_uu_rd_tracker_if.sv
// Issue/retire/busy-register signals between ID/EXE, the tracker and FP_busy_registers.
// The slave modport is the tracker itself; the master modport is its environment.
interface fp_uu_rd_tracker_if;
    import fp_uu_pkg::*;

    logic                                        issue_valid;
    logic [FP_REG_AW-1:0]                        issue_rd;
    logic                                        issue_single_cycle;
    logic                                        branch_hazard;
    logic                                        wb_stall;
    logic                                        issue_ready;
    logic [NUM_UU_STAGES-1:0][FP_REG_AW-1:0]     all_uu_FP_rd;
    logic [NUM_UU_STAGES-1:0]                    all_uu_FP_rd_busy;
    logic [NUM_UU_STAGES-1:0]                    uu_valid;
    logic [NUM_UU_STAGES-1:0]                    uu_live;
    logic                                        clear_last;
    logic                                        retire_valid;
    logic [FP_REG_AW-1:0]                        retire_rd;
    logic [UU_CNT_W-1:0]                         uu_count;
    logic                                        uu_empty;

    modport slave (
        input  issue_valid, issue_rd, issue_single_cycle, branch_hazard, wb_stall,
        input  all_uu_FP_rd_busy,
        output issue_ready, all_uu_FP_rd, uu_valid, uu_live, clear_last,
        output retire_valid, retire_rd, uu_count, uu_empty
    );

    modport master (
        output issue_valid, issue_rd, issue_single_cycle, branch_hazard, wb_stall,
        output all_uu_FP_rd_busy,
        input  issue_ready, all_uu_FP_rd, uu_valid, uu_live, clear_last,
        input  retire_valid, retire_rd, uu_count, uu_empty
    );

endinterface

// File: rtl/fp_uu_rd_tracker_stage.sv
// One pipeline slot of the rd tracker: clear wins over load, otherwise the entry holds.
module fp_uu_stage
    import fp_uu_pkg::*;
(
    input  logic      clk,
    input  logic      clear_i,
    input  logic      load_i,
    input  uu_entry_t d_i,
    output uu_entry_t q_o
);

    uu_entry_t entry_q;

    always_ff @(posedge clk) begin
        if (clear_i) begin
            entry_q <= '0;
        end else if (load_i) begin
            entry_q <= d_i;
        end
    end

    assign q_o = entry_q;

endmodule

// File: rtl/fp_uu_rd_tracker.sv
// Tracks destination FP registers in flight through the pipelined FP unit, blocks
// WAW issue onto an in-flight rd and retires the last stage toward write-back.
module fp_uu_rd_tracker
    import fp_uu_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    fp_uu_rd_tracker_if.slave   uu
);

    localparam int N = NUM_UU_STAGES;

    uu_entry_t           stage_q [N];
    uu_entry_t           stage_d [N];
    logic                waw_hit;
    logic                accept;
    logic                retire;
    logic [UU_CNT_W-1:0] uu_count_q;
    logic [UU_CNT_W-1:0] uu_count_d;

    // The retiring stage still counts, so an rd cannot re-issue in its own retire cycle.
    always_comb begin
        waw_hit = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (stage_q[i].valid && (stage_q[i].rd == uu.issue_rd)) begin
                waw_hit = 1'b1;
            end
        end
    end

    assign uu.issue_ready = ~uu.wb_stall & ~waw_hit;
    assign accept = uu.issue_valid & uu.issue_ready & ~uu.issue_single_cycle & ~uu.branch_hazard;
    assign retire = stage_q[N-1].valid & ~uu.wb_stall;

    // Stage 0 keeps its stale rd on a bubble; later stages shift whatever they receive.
    always_comb begin
        stage_d[0].valid = accept;
        stage_d[0].rd    = accept ? uu.issue_rd : stage_q[0].rd;
        for (int i = 1; i < N; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_stage
        fp_uu_stage u_stage (
            .clk     (clk),
            .clear_i (reset),
            .load_i  (~uu.wb_stall),
            .d_i     (stage_d[g]),
            .q_o     (stage_q[g])
        );
    end

    always_comb begin
        uu_count_d = uu_count_q;
        if (accept && !retire) begin
            uu_count_d = uu_count_q + UU_CNT_W'(1);
        end else if (retire && !accept) begin
            uu_count_d = uu_count_q - UU_CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            uu_count_q <= '0;
        end else begin
            uu_count_q <= uu_count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            uu.all_uu_FP_rd[i] = stage_q[i].rd;
            uu.uu_valid[i]     = stage_q[i].valid;
            uu.uu_live[i]      = stage_q[i].valid & uu.all_uu_FP_rd_busy[i];
        end
    end

    assign uu.retire_valid = retire;
    assign uu.clear_last   = retire & uu.all_uu_FP_rd_busy[N-1];
    assign uu.retire_rd    = stage_q[N-1].rd;
    assign uu.uu_count     = uu_count_q;
    assign uu.uu_empty     = (uu_count_q == '0);

endmodule

// File: tb/tb_fp_uu_rd_tracker.sv
// Bench for fp_uu_rd_tracker: directed scenarios plus random traffic, all checked each
// cycle against a queue of in-flight instructions tagged with their age in the unit.
module tb_fp_uu_rd_tracker;
    import fp_uu_pkg::*;

    localparam int N = NUM_UU_STAGES;

    logic clk;
    logic reset;

    fp_uu_rd_tracker_if bus();

    fp_uu_rd_tracker dut (
        .clk   (clk),
        .reset (reset),
        .uu    (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [FP_REG_AW-1:0] rd;
        int                   age;
    } flight_t;

    flight_t inflight[$];
    int      n_vec;
    int      n_err;
    bit      m_ready;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs derived from the in-flight list and the current inputs.
    task automatic check_model();
        logic [N-1:0]         ev;
        logic [FP_REG_AW-1:0] erd [N];
        bit                   waw;
        bit                   ret;
        logic [FP_REG_AW-1:0] rrd;
        int                   pop;
        ev  = '0;
        waw = 0;
        ret = 0;
        rrd = '0;
        for (int i = 0; i < N; i++) erd[i] = '0;
        foreach (inflight[k]) begin
            ev[inflight[k].age]  = 1'b1;
            erd[inflight[k].age] = inflight[k].rd;
            if (inflight[k].rd == bus.issue_rd) waw = 1;
            if (inflight[k].age == N-1) begin
                ret = !bus.wb_stall;
                rrd = inflight[k].rd;
            end
        end
        m_ready = !bus.wb_stall && !waw;
        cmp("uu_valid", 32'(bus.uu_valid), 32'(ev));
        cmp("uu_live", 32'(bus.uu_live), 32'(ev & bus.all_uu_FP_rd_busy));
        cmp("issue_ready", 32'(bus.issue_ready), 32'(m_ready));
        cmp("retire_valid", 32'(bus.retire_valid), 32'(ret));
        cmp("clear_last", 32'(bus.clear_last), 32'(ret && bus.all_uu_FP_rd_busy[N-1]));
        cmp("uu_count", 32'(bus.uu_count), 32'(inflight.size()));
        cmp("uu_empty", 32'(bus.uu_empty), 32'(inflight.size() == 0));
        if (ret) cmp("retire_rd", 32'(bus.retire_rd), 32'(rrd));
        for (int i = 0; i < N; i++) begin
            if (ev[i]) cmp($sformatf("all_uu_FP_rd[%0d]", i), 32'(bus.all_uu_FP_rd[i]), 32'(erd[i]));
        end
        pop = $countones(bus.uu_valid);
        cmp("count_vs_popcount", 32'(bus.uu_count), 32'(pop));
    endtask

    task automatic model_update(input bit rst, input bit acc, input bit stall, input logic [FP_REG_AW-1:0] rd);
        flight_t nq[$];
        if (rst) begin
            inflight.delete();
        end else if (!stall) begin
            foreach (inflight[k]) begin
                if (inflight[k].age < N-1) nq.push_back('{rd: inflight[k].rd, age: inflight[k].age + 1});
            end
            if (acc) nq.push_back('{rd: rd, age: 0});
            inflight = nq;
        end
    endtask

    // Drive one cycle's inputs and check at the falling edge; caller may add literals then adv().
    task automatic cyc(input bit rst, input bit iv, input logic [FP_REG_AW-1:0] rd,
                       input bit sc, input bit bh, input bit st, input logic [N-1:0] busy);
        reset                  = rst;
        bus.issue_valid        = iv;
        bus.issue_rd           = rd;
        bus.issue_single_cycle = sc;
        bus.branch_hazard      = bh;
        bus.wb_stall           = st;
        bus.all_uu_FP_rd_busy  = busy;
        @(negedge clk);
        check_model();
    endtask

    task automatic adv();
        bit acc;
        acc = bus.issue_valid && m_ready && !bus.issue_single_cycle && !bus.branch_hazard;
        @(posedge clk);
        model_update(reset, acc, bus.wb_stall, bus.issue_rd);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, '0, 0, 0, 0, '1);
            adv();
        end
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, '0, 0, 0, 0, '0);
            adv();
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.issue_valid = 0; bus.issue_rd = '0; bus.issue_single_cycle = 0;
        bus.branch_hazard = 0; bus.wb_stall = 0; bus.all_uu_FP_rd_busy = '0;
        #1;
        do_reset();
        cmp("reset_empty", 32'(bus.uu_empty), 32'd1);

        // 1: single issue, latency N
        cyc(0, 1, 5'd5, 0, 0, 0, 3'b000); adv();
        cyc(0, 0, '0, 0, 0, 0, 3'b000); cmp("t1_c1_valid", 32'(bus.uu_valid), 32'b001); adv();
        cyc(0, 0, '0, 0, 0, 0, 3'b000); cmp("t1_c2_valid", 32'(bus.uu_valid), 32'b010); adv();
        cyc(0, 0, '0, 0, 0, 0, 3'b100);
        cmp("t1_c3_valid", 32'(bus.uu_valid), 32'b100);
        cmp("t1_retire_valid", 32'(bus.retire_valid), 32'd1);
        cmp("t1_retire_rd", 32'(bus.retire_rd), 32'd5);
        cmp("t1_clear_last", 32'(bus.clear_last), 32'd1);
        adv();
        cyc(0, 0, '0, 0, 0, 0, 3'b000); cmp("t1_c4_empty", 32'(bus.uu_empty), 32'd1); adv();

        // 2: stall freezes the pipe
        cyc(0, 1, 5'd7, 0, 0, 0, '1); adv();
        idle(1);
        cyc(0, 0, '0, 0, 0, 1, '1); cmp("t2_stall_valid", 32'(bus.uu_valid), 32'b010); adv();
        cyc(0, 0, '0, 0, 0, 1, '1); cmp("t2_stall_count", 32'(bus.uu_count), 32'd1); adv();
        cyc(0, 0, '0, 0, 0, 0, '1); adv();
        cyc(0, 0, '0, 0, 0, 0, '1);
        cmp("t2_c5_retire", 32'(bus.retire_valid), 32'd1);
        cmp("t2_c5_rd", 32'(bus.retire_rd), 32'd7);
        adv();

        // 3: WAW blocking including the retiring cycle
        cyc(0, 1, 5'd9, 0, 0, 0, '1); adv();
        cyc(0, 1, 5'd9, 0, 0, 0, '1); cmp("t3_waw_c1", 32'(bus.issue_ready), 32'd0); adv();
        cyc(0, 1, 5'd10, 0, 0, 0, '1); cmp("t3_rd10_ready", 32'(bus.issue_ready), 32'd1); adv();
        cyc(0, 1, 5'd9, 0, 0, 0, '1); cmp("t3_waw_retiring", 32'(bus.issue_ready), 32'd0); adv();
        cyc(0, 1, 5'd9, 0, 0, 0, '1); cmp("t3_after_retire", 32'(bus.issue_ready), 32'd1); adv();
        idle(4);

        // 4: back-to-back with accept in the retire cycle
        cyc(0, 1, 5'd1, 0, 0, 0, '1); adv();
        cyc(0, 1, 5'd2, 0, 0, 0, '1); adv();
        cyc(0, 1, 5'd3, 0, 0, 0, '1); adv();
        cyc(0, 1, 5'd4, 0, 0, 0, '1);
        cmp("t4_retire_rd1", 32'(bus.retire_rd), 32'd1);
        cmp("t4_count_c3", 32'(bus.uu_count), 32'd3);
        adv();
        cyc(0, 0, '0, 0, 0, 0, '1);
        cmp("t4_count_c4", 32'(bus.uu_count), 32'd3);
        cmp("t4_retire_rd2", 32'(bus.retire_rd), 32'd2);
        adv();
        cyc(0, 0, '0, 0, 0, 0, '1); cmp("t4_retire_rd3", 32'(bus.retire_rd), 32'd3); adv();
        cyc(0, 0, '0, 0, 0, 0, '1); cmp("t4_retire_rd4", 32'(bus.retire_rd), 32'd4); adv();

        // 5: untracked issues, then rd 0 tracked
        cyc(0, 1, 5'd0, 1, 0, 0, '1); adv();
        cyc(0, 1, 5'd0, 0, 1, 0, '1); cmp("t5_sc_empty", 32'(bus.uu_empty), 32'd1); adv();
        cyc(0, 0, '0, 0, 0, 0, '1); cmp("t5_bh_empty", 32'(bus.uu_empty), 32'd1); adv();
        cyc(0, 1, 5'd0, 0, 0, 0, '1); adv();
        idle(2);
        cyc(0, 0, '0, 0, 0, 0, '1);
        cmp("t5_rd0_retire", 32'(bus.retire_valid), 32'd1);
        cmp("t5_rd0_rd", 32'(bus.retire_rd), 32'd0);
        adv();

        // 6: reset mid-flight
        cyc(0, 1, 5'd11, 0, 0, 0, '1); adv();
        cyc(0, 1, 5'd12, 0, 0, 0, '1); adv();
        cyc(0, 1, 5'd13, 0, 0, 0, '1); adv();
        cyc(1, 0, '0, 0, 0, 0, '1); cmp("t6_full", 32'(bus.uu_valid), 32'b111); adv();
        cyc(0, 0, 5'd11, 0, 0, 0, '1);
        cmp("t6_valid", 32'(bus.uu_valid), 32'd0);
        cmp("t6_count", 32'(bus.uu_count), 32'd0);
        cmp("t6_no_retire", 32'(bus.retire_valid), 32'd0);
        cmp("t6_ready", 32'(bus.issue_ready), 32'd1);
        adv();

        // Random traffic; a small rd range keeps WAW hits frequent.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                ($urandom_range(0, 3) != 0),
                5'($urandom_range(0, 5)),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 3) == 0),
                3'($urandom));
            adv();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
